input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 14 +
 rtl/input_conditioner_ch.sv | 65 ++++++
 rtl/input_conditioner.sv | 41 ++++
 tb/tb_input_conditioner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared defaults and helpers for the input conditioner.
// Each raw input goes through a synchroniser and then a debounce filter.
package input_conditioner_pkg;

  localparam int DEF_CHANNELS       = 4;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_DEBOUNCE_TICKS = 16;

  // The debounce counter only ever holds 0..ticks-1, so a single bit is enough for tiny tick counts.
  function automatic int cnt_width(input int ticks);
    return (ticks <= 2) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One conditioned channel: optional inversion, a synchroniser chain, a debounce counter,
// and registered edge pulses that line up with the first cycle of the new clean level.
module input_conditioner_ch
  import input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic INVERT         = 1'b0,
  parameter logic RESET_VALUE    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sig,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   s;
  logic                   differ;
  logic                   accept;

  assign s      = sync_q[SYNC_STAGES-1];
  assign differ = (s != clean);
  assign accept = differ && tick && (cnt_q == CNT_LAST);

  // The synchroniser samples on every edge; tick only paces the debounce counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig ^ INVERT};
    end
  end

  // Any return to the accepted level wipes the count, so a glitch leaves no partial credit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      clean <= RESET_VALUE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept && s;
      fall <= accept && !s;
      if (!differ) begin
        cnt_q <= '0;
      end else if (tick) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          clean <= s;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: independent per-channel synchronise/debounce filters,
// plus a combined event flag.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int                  CHANNELS       = DEF_CHANNELS,
  parameter int                  SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int                  DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic [CHANNELS-1:0] INVERT         = '0,
  parameter logic [CHANNELS-1:0] RESET_VALUE    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [CHANNELS-1:0] sig,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_event
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_conditioner_ch #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .INVERT        (INVERT[i]),
      .RESET_VALUE   (RESET_VALUE[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .sig  (sig[i]),
      .clean(clean[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign any_event = (|rise) || (|fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random stimulus, all scored against
// a level/streak reference model through an expected-output queue.
module tb_input_conditioner;

  localparam int             CH  = 4;
  localparam int             SS  = 2;
  localparam int             DT  = 4;
  localparam logic [CH-1:0]  INV = 4'b1000;
  localparam logic [CH-1:0]  RV  = 4'b0000;
  localparam int             W   = 3 * CH + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic          tick;
  logic [CH-1:0] sig;
  logic [CH-1:0] clean;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          any_event;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  input_conditioner #(
    .CHANNELS      (CH),
    .SYNC_STAGES   (SS),
    .DEBOUNCE_TICKS(DT),
    .INVERT        (INV),
    .RESET_VALUE   (RV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .sig      (sig),
    .clean    (clean),
    .rise     (rise),
    .fall     (fall),
    .any_event(any_event)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  // Reference model: the conditioned level seen SS edges late, and the run length of
  // qualifying ticks during which that level has disagreed with the accepted output.
  logic [CH-1:0] dq[$];
  logic [CH-1:0] m_clean;
  logic [CH-1:0] m_rise;
  logic [CH-1:0] m_fall;
  int            streak[CH];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    dq.delete();
    for (int i = 0; i < SS; i++) dq.push_back(RV);
    m_clean = RV;
    m_rise  = '0;
    m_fall  = '0;
    for (int i = 0; i < CH; i++) streak[i] = 0;
  endtask

  // Predicts the outputs after the coming rising edge and queues them.
  task automatic model_step();
    logic [CH-1:0] s;
    s = dq.pop_front();
    dq.push_back(sig ^ INV);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < CH; i++) begin
      if (s[i] == m_clean[i]) begin
        streak[i] = 0;
      end else if (tick) begin
        streak[i] = streak[i] + 1;
        if (streak[i] == DT) begin
          m_clean[i] = s[i];
          streak[i]  = 0;
          if (s[i]) m_rise[i] = 1'b1;
          else      m_fall[i] = 1'b1;
        end
      end
    end
    exp_q.push_back({|(m_rise | m_fall), m_clean, m_rise, m_fall});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [CH-1:0] s, input logic t, input logic r);
    @(negedge clk);
    rst  = r;
    sig  = s;
    tick = t;
    if (r) model_step();
    else   model_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clean"}, 16'(clean), 16'(RV));
    check({tag, "_rise"},  16'(rise),  16'd0);
    check({tag, "_fall"},  16'(fall),  16'd0);
    check({tag, "_any"},   16'(any_event), 16'd0);
  endtask

  // Presents a new input and checks the exact edge on which clean changes.
  task automatic run_change(input string tag, input logic [CH-1:0] s,
                            input logic [CH-1:0] prev_clean, input logic [CH-1:0] exp_clean,
                            input logic [CH-1:0] exp_rise, input logic [CH-1:0] exp_fall);
    for (int k = 1; k <= 7; k++) begin
      cycle(s, 1'b1, 1'b1);
      @(posedge clk);
      #2;
      if (k == 5) check({tag, "_edge5_clean"}, 16'(clean), 16'(prev_clean));
      if (k == 6) begin
        check({tag, "_edge6_clean"}, 16'(clean), 16'(exp_clean));
        check({tag, "_edge6_rise"},  16'(rise),  16'(exp_rise));
        check({tag, "_edge6_fall"},  16'(fall),  16'(exp_fall));
        check({tag, "_edge6_any"},   16'(any_event), 16'd1);
      end
      if (k == 7) begin
        check({tag, "_edge7_pulse"}, 16'({rise, fall}), 16'd0);
        check({tag, "_edge7_any"},   16'(any_event), 16'd0);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_w;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_w = exp_q.pop_front();
      check("scoreboard", 16'({any_event, clean, rise, fall}), 16'(mon_w));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b1;
    tick = 1'b1;
    sig  = 4'b1111;
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset_noclk");
    cycle(4'b1111, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0);

    // Channel 0 rises; channel 3 held inactive (its input is active-low).
    run_change("rise0", 4'b1001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

    // A 3-cycle pulse on channel 1 is one tick short of acceptance.
    for (int k = 0; k < 3; k++)  cycle(4'b1011, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) cycle(4'b1001, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    check("glitch1_clean", 16'(clean), 16'(4'b0001));

    // Bring channel 2 high, then release it.
    for (int k = 0; k < 8; k++) cycle(4'b1101, 1'b1, 1'b1);
    run_change("fall2", 4'b1001, 4'b0101, 4'b0001, 4'b0000, 4'b0100);

    // Active-low channel 3 asserted.
    run_change("rise3", 4'b0001, 4'b0001, 4'b1001, 4'b1000, 4'b0000);

    // Slow time base: only every 4th cycle counts.
    for (int k = 1; k <= 24; k++) begin
      cycle(4'b0011, (k % 4) == 0, 1'b1);
      @(posedge clk);
      #2;
      if (k == 15) check("slowtick_before", 16'(clean), 16'(4'b1001));
      if (k == 16) begin
        check("slowtick_accept", 16'(clean), 16'(4'b1011));
        check("slowtick_rise",   16'(rise),  16'(4'b0010));
      end
    end

    // Reset drops clean levels without pulses, then aborts a count in progress.
    cycle(4'b0011, 1'b1, 1'b0);
    #1;
    check_reset_outputs("reset_from_high");
    cycle(4'b1001, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(4'b1001, 1'b1, 1'b1);
    cycle(4'b1001, 1'b1, 1'b0);
    #1;
    check_reset_outputs("reset_midcount");
    run_change("rst_abort", 4'b1001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

    // Random segments of held inputs with a jittery time base and rare resets.
    for (int seg = 0; seg < 60; seg++) begin
      logic [CH-1:0] rs;
      int            hold;
      rs   = CH'($urandom_range(0, (1 << CH) - 1));
      hold = $urandom_range(1, 10);
      for (int k = 0; k < hold; k++) begin
        cycle(rs, $urandom_range(0, 3) != 0, $urandom_range(0, 149) != 0);
      end
    end
    for (int k = 0; k < 12; k++) cycle(4'b1000, 1'b1, 1'b1);

    @(posedge clk);
    #3;
    check("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
